// File: rtl/rotation_addsub_stream.sv
// Frame-buffered rotation stage: x' = cos*x - sin*y, y' = sin*x + cos*y per point,
// with floor/half-up rounding and saturation, streamed LANES points per beat.
module rotation_addsub_stream #(
  parameter  int N_PTS   = 128,
  parameter  int LANES   = 16,
  parameter  int BW_XCOS = 11,
  parameter  int BW_OUT  = 6,
  localparam int NBEATS  = N_PTS / LANES,
  localparam int BEAT_W  = (NBEATS > 1) ? $clog2(NBEATS) : 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic                       round_mode,
  input  logic [N_PTS*BW_XCOS-1:0]   cosx,
  input  logic [N_PTS*BW_XCOS-1:0]   sinx,
  input  logic [N_PTS*BW_XCOS-1:0]   cosy,
  input  logic [N_PTS*BW_XCOS-1:0]   siny,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [LANES*BW_OUT-1:0]    out_x,
  output logic [LANES*BW_OUT-1:0]    out_y,
  output logic [BEAT_W-1:0]          out_beat,
  output logic                       out_last,
  output logic                       sat_flag
);

  localparam int FRAC = BW_XCOS - 6;
  // Two guard bits: one for the add/sub, one so the rounding offset cannot wrap.
  localparam int W2   = BW_XCOS + 2;
  localparam int RND  = 2 ** (FRAC - 1);
  localparam logic signed [W2-1:0] MAXV = W2'(2 ** (BW_OUT - 1) - 1);
  localparam logic signed [W2-1:0] MINV = ~MAXV;

  typedef enum logic {S_IDLE, S_STREAM} state_t;

  state_t                     state_q, state_d;
  logic [N_PTS*BW_XCOS-1:0]   cosx_q, sinx_q, cosy_q, siny_q;
  logic                       round_q;
  logic                       out_valid_q, out_valid_d;
  logic [LANES*BW_OUT-1:0]    out_x_q, out_x_d, out_y_q, out_y_d;
  logic [BEAT_W-1:0]          out_beat_q, out_beat_d;
  logic                       out_last_q, out_last_d;
  logic                       sat_q, sat_d;

  logic                       accept;
  logic [BEAT_W-1:0]          nxt_beat;
  logic [LANES*BW_OUT-1:0]    lane_x, lane_y;
  logic                       lane_sat;
  logic [BW_OUT:0]            rx, ry;

  // Returns {clamped, result} for one coordinate.
  function automatic logic [BW_OUT:0] lane_fn(
    input logic [BW_XCOS-1:0] a,
    input logic [BW_XCOS-1:0] b,
    input logic               sub,
    input logic               rnd
  );
    logic signed [W2-1:0] ea, eb, s, sh;
    ea = $signed({{2{a[BW_XCOS-1]}}, a});
    eb = $signed({{2{b[BW_XCOS-1]}}, b});
    s  = sub ? (ea - eb) : (ea + eb);
    if (rnd) s = s + W2'(RND);
    sh = s >>> FRAC;
    if (sh > MAXV)      return {1'b1, MAXV[BW_OUT-1:0]};
    else if (sh < MINV) return {1'b1, MINV[BW_OUT-1:0]};
    else                return {1'b0, sh[BW_OUT-1:0]};
  endfunction

  assign in_ready = (state_q == S_IDLE) && !rst;
  assign accept   = in_valid && in_ready;
  assign nxt_beat = out_valid_q ? (out_beat_q + 1'b1) : '0;

  always_comb begin
    lane_x   = '0;
    lane_y   = '0;
    lane_sat = 1'b0;
    rx       = '0;
    ry       = '0;
    for (int unsigned j = 0; j < LANES; j++) begin
      rx = lane_fn(cosx_q[(nxt_beat*LANES + j)*BW_XCOS +: BW_XCOS],
                   siny_q[(nxt_beat*LANES + j)*BW_XCOS +: BW_XCOS], 1'b1, round_q);
      ry = lane_fn(sinx_q[(nxt_beat*LANES + j)*BW_XCOS +: BW_XCOS],
                   cosy_q[(nxt_beat*LANES + j)*BW_XCOS +: BW_XCOS], 1'b0, round_q);
      lane_x[j*BW_OUT +: BW_OUT] = rx[BW_OUT-1:0];
      lane_y[j*BW_OUT +: BW_OUT] = ry[BW_OUT-1:0];
      lane_sat = lane_sat | rx[BW_OUT] | ry[BW_OUT];
    end
  end

  always_comb begin
    state_d     = state_q;
    out_valid_d = out_valid_q;
    out_x_d     = out_x_q;
    out_y_d     = out_y_q;
    out_beat_d  = out_beat_q;
    out_last_d  = out_last_q;
    sat_d       = sat_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          state_d    = S_STREAM;
          sat_d      = 1'b0;
          out_beat_d = '0;
        end
      end
      S_STREAM: begin
        // The first STREAM cycle (out_valid low) loads beat 0; later loads follow each handshake.
        if (!out_valid_q || out_ready) begin
          if (out_valid_q && out_last_q) begin
            state_d     = S_IDLE;
            out_valid_d = 1'b0;
            out_last_d  = 1'b0;
            out_beat_d  = '0;
          end else begin
            out_valid_d = 1'b1;
            out_x_d     = lane_x;
            out_y_d     = lane_y;
            out_beat_d  = nxt_beat;
            out_last_d  = (nxt_beat == BEAT_W'(NBEATS - 1));
            sat_d       = sat_q | lane_sat;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      cosx_q  <= cosx;
      sinx_q  <= sinx;
      cosy_q  <= cosy;
      siny_q  <= siny;
      round_q <= round_mode;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      out_valid_q <= 1'b0;
      out_x_q     <= '0;
      out_y_q     <= '0;
      out_beat_q  <= '0;
      out_last_q  <= 1'b0;
      sat_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      out_valid_q <= out_valid_d;
      out_x_q     <= out_x_d;
      out_y_q     <= out_y_d;
      out_beat_q  <= out_beat_d;
      out_last_q  <= out_last_d;
      sat_q       <= sat_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_x     = out_x_q;
  assign out_y     = out_y_q;
  assign out_beat  = out_beat_q;
  assign out_last  = out_last_q;
  assign sat_flag  = sat_q;

endmodule

// File: tb/tb_rotation_addsub_stream.sv
// Scoreboard bench for rotation_addsub_stream: directed frames with hand-computed
// results, a backpressured frame checked against a small model, and a mid-frame reset.
module tb_rotation_addsub_stream;
  localparam int N  = 128;
  localparam int L  = 16;
  localparam int BX = 11;
  localparam int BO = 6;
  localparam int NB = N / L;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic             round_mode;
  logic [N*BX-1:0]  cosx, sinx, cosy, siny;
  logic             out_valid;
  logic             out_ready;
  logic [L*BO-1:0]  out_x, out_y;
  logic [2:0]       out_beat;
  logic             out_last;
  logic             sat_flag;

  rotation_addsub_stream #(.N_PTS(N), .LANES(L), .BW_XCOS(BX), .BW_OUT(BO)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .round_mode(round_mode), .cosx(cosx), .sinx(sinx), .cosy(cosy), .siny(siny),
    .out_valid(out_valid), .out_ready(out_ready), .out_x(out_x), .out_y(out_y),
    .out_beat(out_beat), .out_last(out_last), .sat_flag(sat_flag)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]      beat;
    logic [L*BO-1:0] x;
    logic [L*BO-1:0] y;
    logic            last;
    logic            sat;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  bit   bp_en    = 0;

  int icx[N], isx[N], icy[N], isy[N];
  int ex[N], ey[N];
  bit ec[N];

  function automatic void chk(string name, logic [127:0] act, logic [127:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, req, $time);
    end
  endfunction

  task automatic clear_frame();
    for (int p = 0; p < N; p++) begin
      icx[p] = 0; isx[p] = 0; icy[p] = 0; isy[p] = 0;
      ex[p] = 0; ey[p] = 0; ec[p] = 0;
    end
  endtask

  task automatic set_pt(input int p, input int cx, input int sx, input int cy, input int sy,
                        input int xx, input int yy, input bit c);
    icx[p] = cx; isx[p] = sx; icy[p] = cy; isy[p] = sy;
    ex[p] = xx; ey[p] = yy; ec[p] = c;
  endtask

  function automatic void model_pt(input int a, input int b, input bit sub, input bit rnd,
                                   output int r, output bit c);
    int s;
    s = sub ? (a - b) : (a + b);
    if (rnd) s = s + 16;
    s = s >>> 5;
    c = 0;
    if (s > 31) begin r = 31; c = 1; end
    else if (s < -32) begin r = -32; c = 1; end
    else r = s;
  endfunction

  task automatic model_frame(input bit rnd);
    bit cx_c, cy_c;
    for (int p = 0; p < N; p++) begin
      model_pt(icx[p], isy[p], 1'b1, rnd, ex[p], cx_c);
      model_pt(isx[p], icy[p], 1'b0, rnd, ey[p], cy_c);
      ec[p] = cx_c | cy_c;
    end
  endtask

  task automatic push_exp();
    exp_t e;
    bit   sat_run = 0;
    int   p;
    for (int b = 0; b < NB; b++) begin
      e.beat = 3'(b);
      e.x = '0;
      e.y = '0;
      for (int j = 0; j < L; j++) begin
        p = b * L + j;
        e.x[j*BO +: BO] = ex[p][BO-1:0];
        e.y[j*BO +: BO] = ey[p][BO-1:0];
        sat_run = sat_run | ec[p];
      end
      e.sat  = sat_run;
      e.last = (b == NB - 1);
      exp_q.push_back(e);
    end
  endtask

  task automatic send_frame(input bit rnd);
    int t = 0;
    @(negedge clk);
    for (int p = 0; p < N; p++) begin
      cosx[p*BX +: BX] = icx[p][BX-1:0];
      sinx[p*BX +: BX] = isx[p][BX-1:0];
      cosy[p*BX +: BX] = icy[p][BX-1:0];
      siny[p*BX +: BX] = isy[p][BX-1:0];
    end
    round_mode = rnd;
    in_valid   = 1'b1;
    while (!in_ready && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (!in_ready) begin
      chk("accept_timeout", 1'b0, 1'b1);
      in_valid = 1'b0;
      return;
    end
    @(posedge clk);
    push_exp();
    #1;
    in_valid   = 1'b0;
    round_mode = ~rnd;
    cosx = {44{$urandom}};
    sinx = {44{$urandom}};
    cosy = {44{$urandom}};
    siny = {44{$urandom}};
    @(negedge clk);
    chk("first_cycle_valid", out_valid, 1'b0);
    chk("sat_cleared", sat_flag, 1'b0);
    chk("in_ready_after_accept", in_ready, 1'b0);
    @(negedge clk);
    chk("beat0_valid", out_valid, 1'b1);
    chk("beat0_index", out_beat, 3'd0);
  endtask

  task automatic wait_done();
    int t = 0;
    while (exp_q.size() != 0 && t < 3000) begin
      @(negedge clk);
      t++;
    end
    if (exp_q.size() != 0) begin
      chk("drain_timeout", 32'(exp_q.size()), 32'd0);
      exp_q.delete();
    end
    @(negedge clk);
    chk("idle_in_ready", in_ready, 1'b1);
    chk("idle_out_valid", out_valid, 1'b0);
  endtask

  task automatic frame_a(input bit rnd);
    clear_frame();
    if (!rnd) begin
      set_pt(0,   176, -80,  0, 40,  4, -3, 0);
      set_pt(1,    80,   0,  0,  0,  2,  0, 0);
      set_pt(17,  -33, 100, -4,  0, -2,  3, 0);
      set_pt(127,   0,  31,  0, 32, -1,  0, 0);
    end else begin
      set_pt(0,   176, -80,  0, 40,  4, -2, 0);
      set_pt(1,    80,   0,  0,  0,  3,  0, 0);
      set_pt(17,  -33, 100, -4,  0, -1,  3, 0);
      set_pt(127,   0,  31,  0, 32, -1,  1, 0);
      set_pt(60, 1023,   0,  0,  0, 31,  0, 1);
    end
  endtask

  // Output monitor: compares every presented beat with the scoreboard head.
  always @(negedge clk) begin
    if (!rst && out_valid) begin
      chk("in_ready_busy", in_ready, 1'b0);
      if (exp_q.size() == 0) begin
        chk("unexpected_beat", 1'b1, 1'b0);
      end else begin
        chk("beat", out_beat, exp_q[0].beat);
        chk("out_x", out_x, exp_q[0].x);
        chk("out_y", out_y, exp_q[0].y);
        chk("out_last", out_last, exp_q[0].last);
        chk("sat_flag", sat_flag, exp_q[0].sat);
        if (out_ready) void'(exp_q.pop_front());
      end
    end
  end

  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      out_ready = bp_en ? 1'($urandom_range(1)) : 1'b1;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int t;
    rst = 1'b1; in_valid = 1'b0; round_mode = 1'b0;
    cosx = '0; sinx = '0; cosy = '0; siny = '0;
    #2;
    chk("rst_in_ready", in_ready, 1'b0);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_out_x", out_x, '0);
    chk("rst_out_y", out_y, '0);
    chk("rst_out_beat", out_beat, 3'd0);
    chk("rst_out_last", out_last, 1'b0);
    chk("rst_sat", sat_flag, 1'b0);
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    #1;
    chk("post_rst_in_ready", in_ready, 1'b1);

    frame_a(1'b0); send_frame(1'b0); wait_done();
    frame_a(1'b1); send_frame(1'b1); wait_done();

    clear_frame();
    set_pt(40,  1023,     0,  0, -992,  31,   0, 1);
    set_pt(41,     0, -1024, -1,    0,   0, -32, 1);
    set_pt(50,  1023,     0,  0,    0,  31,   0, 0);
    set_pt(51, -1024,     0,  0,    0, -32,   0, 0);
    set_pt(100, -1024,    0,  0, 1023, -32,   0, 1);
    send_frame(1'b0); wait_done();

    clear_frame();
    for (int p = 0; p < N; p++) begin
      icx[p] = int'($urandom_range(800)) - 400;
      isx[p] = int'($urandom_range(800)) - 400;
      icy[p] = int'($urandom_range(800)) - 400;
      isy[p] = int'($urandom_range(800)) - 400;
    end
    model_frame(1'b1);
    bp_en = 1;
    send_frame(1'b1); wait_done();
    bp_en = 0;

    frame_a(1'b0); send_frame(1'b0);
    t = 0;
    while (!(out_valid && out_beat == 3'd3) && t < 100) begin
      @(negedge clk);
      t++;
    end
    chk("reached_beat3", out_beat, 3'd3);
    #2;
    rst = 1'b1;
    #1;
    chk("mid_rst_out_valid", out_valid, 1'b0);
    chk("mid_rst_out_x", out_x, '0);
    chk("mid_rst_out_y", out_y, '0);
    chk("mid_rst_out_beat", out_beat, 3'd0);
    chk("mid_rst_out_last", out_last, 1'b0);
    chk("mid_rst_in_ready", in_ready, 1'b0);
    @(negedge clk);
    exp_q.delete();
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("mid_rst_release_in_ready", in_ready, 1'b1);

    frame_a(1'b1); send_frame(1'b1); wait_done();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
